// File: rtl/card_dealer.sv
// Blackjack shoe dealer: per-rank counters, rejection sampling of an external random rank stream.
// Optional CARD_DEALER_SCAN_FALLBACK_EN: after RETRY_MAX consecutive misses, a linear scan finds a rank.
module card_dealer #(
  parameter int DECKS     = 1,
  parameter int RETRY_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rnd,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [3:0] card_points,
  output logic       busy,
  output logic       deal_err,
  output logic       deck_empty,
  output logic [7:0] cards_left
);

  localparam logic [4:0] PER_RANK = 5'(4 * DECKS);
  localparam logic [7:0] FULL     = 8'(52 * DECKS);

  if (DECKS < 1 || DECKS > 4 || RETRY_MAX < 1 || RETRY_MAX > 255) begin : g_bad_params
    $error("card_dealer: DECKS must be 1..4 and RETRY_MAX 1..255");
  end

`ifdef CARD_DEALER_SCAN_FALLBACK_EN
  typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, DEAL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SAMPLE, DEAL} state_t;
`endif

  state_t     state, state_d;
  logic [4:0] rank_cnt [0:12];
  logic [3:0] samp_q;
  logic       samp_vld;
  logic       samp_hit;
  logic [3:0] pick;
  logic [3:0] deal_rank;
  logic [3:0] last_rank;
  logic [3:0] last_points;
  logic       deal_err_d;

`ifdef CARD_DEALER_SCAN_FALLBACK_EN
  logic [7:0] miss_cnt;
  logic [3:0] scan_rank;
  logic [3:0] scan_start;
  logic       scan_hit;
`endif

  function automatic logic [3:0] points_of(input logic [3:0] r);
    if (r == 4'd1)       points_of = 4'd11;
    else if (r > 4'd10)  points_of = 4'd10;
    else                 points_of = r;
  endfunction

  // samp_q only holds a genuine sample once a full cycle has been spent in SAMPLE
  always_comb begin
    samp_hit = 1'b0;
    if (samp_q >= 4'd1 && samp_q <= 4'd13)
      samp_hit = (rank_cnt[samp_q - 4'd1] != 5'd0);
  end

`ifdef CARD_DEALER_SCAN_FALLBACK_EN
  assign scan_hit   = (rank_cnt[scan_rank - 4'd1] != 5'd0);
  assign scan_start = (samp_q >= 4'd1 && samp_q <= 4'd13) ? samp_q : 4'd1;
`endif

  always_comb begin
    state_d    = state;
    deal_err_d = 1'b0;
    pick       = samp_q;
    case (state)
      IDLE: begin
        if (deal_req) begin
          if (deck_empty) deal_err_d = 1'b1;
          else            state_d    = SAMPLE;
        end
      end
      SAMPLE: begin
        if (samp_vld) begin
          if (samp_hit) begin
            state_d = DEAL;
            pick    = samp_q;
          end
`ifdef CARD_DEALER_SCAN_FALLBACK_EN
          else if (miss_cnt == 8'(RETRY_MAX - 1)) begin
            state_d = SCAN;
          end
`endif
        end
      end
`ifdef CARD_DEALER_SCAN_FALLBACK_EN
      SCAN: begin
        if (scan_hit) begin
          state_d = DEAL;
          pick    = scan_rank;
        end
      end
`endif
      DEAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset and shuffle both refill the shoe; reset alone also clears the last-card display
  always_ff @(posedge clk) begin
    if (rst || shuffle) begin
      state      <= IDLE;
      samp_vld   <= 1'b0;
      samp_q     <= 4'd0;
      deal_rank  <= 4'd1;
      deal_err   <= 1'b0;
      cards_left <= FULL;
      for (int i = 0; i < 13; i++) rank_cnt[i] <= PER_RANK;
`ifdef CARD_DEALER_SCAN_FALLBACK_EN
      miss_cnt   <= 8'd0;
      scan_rank  <= 4'd1;
`endif
    end else begin
      state    <= state_d;
      deal_err <= deal_err_d;
      samp_vld <= (state == SAMPLE);
      if (state == SAMPLE) samp_q <= rnd;
      if (state_d == DEAL && state != DEAL) deal_rank <= pick;
      if (state == DEAL) begin
        rank_cnt[deal_rank - 4'd1] <= rank_cnt[deal_rank - 4'd1] - 5'd1;
        cards_left                 <= cards_left - 8'd1;
      end
`ifdef CARD_DEALER_SCAN_FALLBACK_EN
      if (state == SAMPLE && samp_vld && !samp_hit) miss_cnt <= miss_cnt + 8'd1;
      else if (state != SAMPLE)                     miss_cnt <= 8'd0;
      if (state == SAMPLE && state_d == SCAN)
        scan_rank <= scan_start;
      else if (state == SCAN && !scan_hit)
        scan_rank <= (scan_rank == 4'd13) ? 4'd1 : scan_rank + 4'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rank   <= 4'd1;
      last_points <= 4'd11;
    end else if (state == DEAL) begin
      last_rank   <= deal_rank;
      last_points <= points_of(deal_rank);
    end
  end

  assign card_valid  = (state == DEAL);
  assign card_rank   = card_valid ? deal_rank : last_rank;
  assign card_points = card_valid ? points_of(deal_rank) : last_points;
  assign busy        = (state != IDLE);
  assign deck_empty  = (cards_left == 8'd0);

endmodule
